// File: rtl/led_seq_ctrl_if.sv
// rtl/led_seq_ctrl_if.sv - command and status bundle between the UART decoder and the LED sequencer
interface led_seq_ctrl_if #(
  parameter int SLOT_N = 8,
  parameter int TIME_W = 32
);
  logic                      cmd_valid;
  logic [SLOT_N-1:0]         ctrl;
  logic [TIME_W-1:0]         time_set;
  logic                      led;
  logic [$clog2(SLOT_N)-1:0] slot_idx;
  logic                      busy;
  logic                      cycle_done;
  logic                      pending;

  modport master (
    output cmd_valid, ctrl, time_set,
    input  led, slot_idx, busy, cycle_done, pending
  );

  modport slave (
    input  cmd_valid, ctrl, time_set,
    output led, slot_idx, busy, cycle_done, pending
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED pattern sequencer; LED_SEQ_SYNC_UPDATE_EN defers RUN commands to the wrap
// boundary through a shadow register instead of restarting immediately.
module led_seq_ctrl #(
  parameter int SLOT_N = 8,
  parameter int TIME_W = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  led_seq_ctrl_if.slave   bus
);
  localparam int IDX_W = $clog2(SLOT_N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [SLOT_N-1:0]   pattern, pattern_nxt;
  logic [TIME_W-1:0]   period, period_nxt;
  logic [TIME_W-1:0]   timer, timer_nxt;
  logic [IDX_W-1:0]    slot, slot_nxt;
  logic                led_q, led_nxt;
  logic                done_q, done_nxt;
  logic                boundary, wrap;
  logic [IDX_W-1:0]    slot_inc;

`ifdef LED_SEQ_SYNC_UPDATE_EN
  logic [SLOT_N-1:0]   sh_ctrl, sh_ctrl_nxt;
  logic [TIME_W-1:0]   sh_time, sh_time_nxt;
  logic                pending_q, pending_nxt;
  logic                idle_apply;
  logic [SLOT_N-1:0]   idle_ctrl;
  logic [TIME_W-1:0]   idle_time;
`endif

  assign boundary = (state == RUN) && (timer == period - TIME_W'(1));
  assign wrap     = boundary && (slot == IDX_W'(SLOT_N - 1));
  assign slot_inc = slot + IDX_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pattern <= '0;
      period  <= '0;
      timer   <= '0;
      slot    <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_SEQ_SYNC_UPDATE_EN
      sh_ctrl   <= '0;
      sh_time   <= '0;
      pending_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
      period  <= period_nxt;
      timer   <= timer_nxt;
      slot    <= slot_nxt;
      led_q   <= led_nxt;
      done_q  <= done_nxt;
`ifdef LED_SEQ_SYNC_UPDATE_EN
      sh_ctrl   <= sh_ctrl_nxt;
      sh_time   <= sh_time_nxt;
      pending_q <= pending_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    period_nxt  = period;
    timer_nxt   = timer;
    slot_nxt    = slot;
    led_nxt     = led_q;
    done_nxt    = 1'b0;
`ifdef LED_SEQ_SYNC_UPDATE_EN
    sh_ctrl_nxt = sh_ctrl;
    sh_time_nxt = sh_time;
    pending_nxt = pending_q;
    // A shadow left over from a same-cycle command at a stopping wrap is honoured once idle.
    idle_apply  = bus.cmd_valid || pending_q;
    idle_ctrl   = bus.cmd_valid ? bus.ctrl : sh_ctrl;
    idle_time   = bus.cmd_valid ? bus.time_set : sh_time;
`endif

    case (state)
      IDLE: begin
        led_nxt = 1'b0;
`ifdef LED_SEQ_SYNC_UPDATE_EN
        if (idle_apply) begin
          pending_nxt = 1'b0;
          if (idle_time != '0) begin
            state_nxt   = RUN;
            pattern_nxt = idle_ctrl;
            period_nxt  = idle_time;
            timer_nxt   = '0;
            slot_nxt    = '0;
            led_nxt     = idle_ctrl[0];
          end
        end
`else
        if (bus.cmd_valid && bus.time_set != '0) begin
          state_nxt   = RUN;
          pattern_nxt = bus.ctrl;
          period_nxt  = bus.time_set;
          timer_nxt   = '0;
          slot_nxt    = '0;
          led_nxt     = bus.ctrl[0];
        end
`endif
      end

      RUN: begin
        if (boundary) begin
          timer_nxt = '0;
          slot_nxt  = slot_inc;
          led_nxt   = pattern[slot_inc];
          done_nxt  = wrap;
        end else begin
          timer_nxt = timer + TIME_W'(1);
        end
`ifdef LED_SEQ_SYNC_UPDATE_EN
        if (bus.cmd_valid) begin
          sh_ctrl_nxt = bus.ctrl;
          sh_time_nxt = bus.time_set;
          pending_nxt = 1'b1;
        end
        if (wrap && pending_q) begin
          pending_nxt = bus.cmd_valid;
          slot_nxt    = '0;
          timer_nxt   = '0;
          if (sh_time == '0) begin
            state_nxt = IDLE;
            led_nxt   = 1'b0;
          end else begin
            pattern_nxt = sh_ctrl;
            period_nxt  = sh_time;
            led_nxt     = sh_ctrl[0];
          end
        end
`else
        // A command overrides a coincident slot boundary, so an aborted cycle never reports done.
        if (bus.cmd_valid) begin
          done_nxt  = 1'b0;
          timer_nxt = '0;
          slot_nxt  = '0;
          if (bus.time_set == '0) begin
            state_nxt = IDLE;
            led_nxt   = 1'b0;
          end else begin
            pattern_nxt = bus.ctrl;
            period_nxt  = bus.time_set;
            led_nxt     = bus.ctrl[0];
          end
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
        led_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.led        = led_q;
  assign bus.slot_idx   = slot;
  assign bus.busy       = (state == RUN);
  assign bus.cycle_done = done_q;
`ifdef LED_SEQ_SYNC_UPDATE_EN
  assign bus.pending    = pending_q;
`else
  assign bus.pending    = 1'b0;
`endif
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed vectors for led_seq_ctrl
module tb_led_seq_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  led_seq_ctrl_if #(.SLOT_N(8), .TIME_W(32)) bus ();

  led_seq_ctrl #(.SLOT_N(8), .TIME_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.cmd_valid = 1'b0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] c, input logic [31:0] t);
    bus.cmd_valid = 1'b1;
    bus.ctrl      = c;
    bus.time_set  = t;
    tick();
    bus.cmd_valid = 1'b0;
    bus.ctrl      = 8'h5A;
    bus.time_set  = 32'd7;
  endtask

  logic [7:0] pat;
  int         slot_e;
  int         dones;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.ctrl      = '0;
    bus.time_set  = '0;

    // reset state
    do_reset();
    chk("rst_led", bus.led, 0);
    chk("rst_slot", bus.slot_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.cycle_done, 0);
    chk("rst_pending", bus.pending, 0);

    // zero time_set in IDLE stays idle
    strobe(8'hFF, 32'd0);
    chk("idle_zero_busy", bus.busy, 0);

    // pattern A5, 3-cycle slots, two full cycles
    pat = 8'b1010_0101;
    strobe(pat, 32'd3);
    for (int k = 0; k < 48; k++) begin
      slot_e = (k / 3) % 8;
      chk("t1_led", bus.led, pat[slot_e]);
      chk("t1_slot", bus.slot_idx, slot_e);
      chk("t1_busy", bus.busy, 1);
      chk("t1_done", bus.cycle_done, (k % 24 == 0 && k > 0) ? 1 : 0);
      tick();
    end

    // stop from RUN with period 1
    do_reset();
    strobe(8'h02, 32'd1);
    tick(5);
    strobe(8'hFF, 32'd0);
    chk("t2_led", bus.led, 0);
    chk("t2_busy", bus.busy, 0);
    chk("t2_slot", bus.slot_idx, 0);
    chk("t2_done", bus.cycle_done, 0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.cycle_done) dones++;
    end
    chk("t2_no_done", dones, 0);

    do_reset();
    pat = 8'b1010_0101;
    strobe(pat, 32'd3);
    tick(13);
    chk("t3_mid_slot4", bus.slot_idx, 4);
`ifndef LED_SEQ_SYNC_UPDATE_EN
    // immediate restart mid-slot
    strobe(8'hFF, 32'd2);
    chk("t3_slot", bus.slot_idx, 0);
    chk("t3_led", bus.led, 1);
    chk("t3_done", bus.cycle_done, 0);
    chk("t3_pending", bus.pending, 0);
    tick(2);
    chk("t3_slot1", bus.slot_idx, 1);
    tick(13);
    chk("t3_slot7", bus.slot_idx, 7);
    // command coincident with wrap boundary wins
    strobe(8'h01, 32'd1);
    chk("t3b_slot", bus.slot_idx, 0);
    chk("t3b_led", bus.led, 1);
    chk("t3b_done", bus.cycle_done, 0);
    chk("t3b_busy", bus.busy, 1);
    tick();
    chk("t3b_led2", bus.led, 0);
`else
    // deferred update, second strobe wins
    strobe(8'hFF, 32'd2);
    chk("t4_pending", bus.pending, 1);
    chk("t4_slot", bus.slot_idx, 4);
    chk("t4_led", bus.led, 0);
    tick(2);
    strobe(8'h0F, 32'd1);
    chk("t4_pending2", bus.pending, 1);
    tick(6);
    chk("t4_slot7", bus.slot_idx, 7);
    chk("t4_pre_done", bus.cycle_done, 0);
    tick();
    chk("t4_done", bus.cycle_done, 1);
    chk("t4_pending_clr", bus.pending, 0);
    chk("t4_new_slot", bus.slot_idx, 0);
    chk("t4_new_led", bus.led, 1);
    tick();
    chk("t4_p1_slot", bus.slot_idx, 1);
    tick(3);
    chk("t4_p1_slot4", bus.slot_idx, 4);
    chk("t4_p1_led", bus.led, 0);
`endif

    // reset wins over a coincident command
    do_reset();
    strobe(8'hA5, 32'd3);
    tick(5);
    Reset = 1'b1;
    strobe(8'hFF, 32'd5);
    Reset = 1'b0;
    chk("t5_led", bus.led, 0);
    chk("t5_slot", bus.slot_idx, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.cycle_done, 0);
    chk("t5_pending", bus.pending, 0);
    tick(3);
    chk("t5_still_idle", bus.busy, 0);

    // maximum period near terminal count
    do_reset();
    strobe(8'h02, 32'hFFFF_FFFF);
    chk("t6_slot0", bus.slot_idx, 0);
    chk("t6_led0", bus.led, 0);
    force dut.timer = 32'hFFFF_FFFD;
    #1;
    release dut.timer;
    tick();
    chk("t6_timer_fe", dut.timer, 32'hFFFF_FFFE);
    chk("t6_slot_hold", bus.slot_idx, 0);
    tick();
    chk("t6_slot1", bus.slot_idx, 1);
    chk("t6_led1", bus.led, 1);
    chk("t6_timer0", dut.timer, 0);
    chk("t6_busy", bus.busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
